// File: rtl/ap1000_bp_dcm_reset_sequencer_if.sv
// Signal bundle between the board-level lock/request sources and the DCM reset sequencer.
// The master drives the lock inputs and software reset request; the slave returns the sequenced resets and status.
interface ap1000_bp_dcm_reset_sequencer_if;
  logic       plb_dcm_locked;
  logic       opb_dcm_locked;
  logic       ddr_fb_dcm_locked;
  logic       cpu_sw_rst_req;
  logic       plb_dcm_rst;
  logic       seq_rst_plb;
  logic       seq_rst_opb;
  logic       seq_rst_cpu;
  logic       dcm_fault;
  logic [2:0] seq_state;
  logic [3:0] retry_cnt;
  logic [7:0] lock_lost_cnt;

  modport master (
    output plb_dcm_locked, opb_dcm_locked, ddr_fb_dcm_locked, cpu_sw_rst_req,
    input  plb_dcm_rst, seq_rst_plb, seq_rst_opb, seq_rst_cpu, dcm_fault,
           seq_state, retry_cnt, lock_lost_cnt
  );

  modport slave (
    input  plb_dcm_locked, opb_dcm_locked, ddr_fb_dcm_locked, cpu_sw_rst_req,
    output plb_dcm_rst, seq_rst_plb, seq_rst_opb, seq_rst_cpu, dcm_fault,
           seq_state, retry_cnt, lock_lost_cnt
  );
endinterface

// File: rtl/ap1000_bp_dcm_reset_sequencer.sv
// Brings up the PLB/OPB/DDR-feedback DCMs on the raw board clock.
// It then releases the PLB, OPB and CPU resets in stages and restarts the whole sequence on any loss of lock.
module ap1000_bp_dcm_reset_sequencer #(
  parameter int DCM_RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT      = 65535,
  parameter int MAX_RETRIES       = 3,
  parameter int SETTLE_CYCLES     = 256,
  parameter int STAGE_GAP         = 16,
  parameter int CPU_SW_RST_CYCLES = 32
) (
  input  logic                                  fpga_plb_clk,
  input  logic                                  fpga_rst,
  ap1000_bp_dcm_reset_sequencer_if.slave        bus
);

  typedef enum logic [2:0] {
    DCM_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    STAGE     = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_e;

  localparam logic [15:0] DCM_RST_LAST = 16'(DCM_RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST     = 16'(STAGE_GAP - 1);
  localparam logic [15:0] SW_LAST      = 16'(CPU_SW_RST_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRIES);

  logic [2:0]  sync1_q, sync2_q;
  logic        all_locked;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        dcm_rst_q, dcm_rst_d;
  logic        rst_plb_q, rst_plb_d;
  logic        rst_opb_q, rst_opb_d;
  logic        rst_cpu_q, rst_cpu_d;
  logic        fault_q, fault_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  lost_q, lost_d;

  assign all_locked = &sync2_q;

  // One shared counter times the DCM reset pulse, lock timeout, settle window, stage gaps and the sw CPU stretch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dcm_rst_d = dcm_rst_q;
    rst_plb_d = rst_plb_q;
    rst_opb_d = rst_opb_q;
    rst_cpu_d = rst_cpu_q;
    fault_d   = fault_q;
    retry_d   = retry_q;
    lost_d    = lost_q;

    case (state_q)
      DCM_RST: begin
        dcm_rst_d = 1'b1;
        if (cnt_q == DCM_RST_LAST) begin
          state_d   = WAIT_LOCK;
          dcm_rst_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_LOCK: begin
        if (all_locked) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d   = retry_q + 4'd1;
          cnt_d     = '0;
          dcm_rst_d = 1'b1;
          if (retry_q + 4'd1 == RETRY_MAX) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = DCM_RST;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SETTLE: begin
        if (!all_locked) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d   = STAGE;
          rst_plb_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STAGE: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (rst_opb_q) begin
            rst_opb_d = 1'b0;
          end else begin
            rst_cpu_d = 1'b0;
            retry_d   = '0;
            state_d   = RUN;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN: begin
        if (rst_cpu_q) begin
          if (cnt_q == SW_LAST) begin
            rst_cpu_d = 1'b0;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else if (bus.cpu_sw_rst_req) begin
          rst_cpu_d = 1'b1;
          cnt_d     = '0;
        end
      end
      FAULT: begin
        dcm_rst_d = 1'b1;
        rst_plb_d = 1'b1;
        rst_opb_d = 1'b1;
        rst_cpu_d = 1'b1;
        fault_d   = 1'b1;
      end
      default: begin
        state_d   = DCM_RST;
        cnt_d     = '0;
        dcm_rst_d = 1'b1;
        rst_plb_d = 1'b1;
        rst_opb_d = 1'b1;
        rst_cpu_d = 1'b1;
      end
    endcase

    // Lock loss after release outranks stage progress and any sw stretch in flight.
    if ((state_q == STAGE || state_q == RUN) && !all_locked) begin
      state_d   = DCM_RST;
      cnt_d     = '0;
      dcm_rst_d = 1'b1;
      rst_plb_d = 1'b1;
      rst_opb_d = 1'b1;
      rst_cpu_d = 1'b1;
      if (lost_q != 8'hFF) begin
        lost_d = lost_q + 8'd1;
      end
    end
  end

  always_ff @(posedge fpga_plb_clk) begin
    if (fpga_rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= DCM_RST;
      cnt_q     <= '0;
      dcm_rst_q <= 1'b1;
      rst_plb_q <= 1'b1;
      rst_opb_q <= 1'b1;
      rst_cpu_q <= 1'b1;
      fault_q   <= 1'b0;
      retry_q   <= '0;
      lost_q    <= '0;
    end else begin
      sync1_q   <= {bus.ddr_fb_dcm_locked, bus.opb_dcm_locked, bus.plb_dcm_locked};
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dcm_rst_q <= dcm_rst_d;
      rst_plb_q <= rst_plb_d;
      rst_opb_q <= rst_opb_d;
      rst_cpu_q <= rst_cpu_d;
      fault_q   <= fault_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
    end
  end

  assign bus.plb_dcm_rst   = dcm_rst_q;
  assign bus.seq_rst_plb   = rst_plb_q;
  assign bus.seq_rst_opb   = rst_opb_q;
  assign bus.seq_rst_cpu   = rst_cpu_q;
  assign bus.dcm_fault     = fault_q;
  assign bus.seq_state     = state_q;
  assign bus.retry_cnt     = retry_q;
  assign bus.lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_ap1000_bp_dcm_reset_sequencer.sv
// Directed bench for the DCM reset sequencer: expected output snapshots are queued with each stimulus step
// and popped for comparison once the DUT has had the stated number of cycles to respond.
module tb_ap1000_bp_dcm_reset_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  typedef struct {
    string       tag;
    logic [19:0] exp;
  } exp_t;

  exp_t exp_q[$];

  ap1000_bp_dcm_reset_sequencer_if bus ();

  ap1000_bp_dcm_reset_sequencer #(
    .DCM_RST_CYCLES   (4),
    .LOCK_TIMEOUT     (20),
    .MAX_RETRIES      (3),
    .SETTLE_CYCLES    (8),
    .STAGE_GAP        (4),
    .CPU_SW_RST_CYCLES(6)
  ) dut (
    .fpga_plb_clk(clk),
    .fpga_rst    (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot layout: state[19:17] dcm_rst plb opb cpu fault retry[11:8] lost[7:0]
  function automatic logic [19:0] mk(input logic [2:0] st, input logic dcm, input logic plb,
                                     input logic opb, input logic cpu, input logic flt,
                                     input logic [3:0] rty, input logic [7:0] lost);
    return {st, dcm, plb, opb, cpu, flt, rty, lost};
  endfunction

  function automatic logic [19:0] sample();
    return {bus.seq_state, bus.plb_dcm_rst, bus.seq_rst_plb, bus.seq_rst_opb, bus.seq_rst_cpu,
            bus.dcm_fault, bus.retry_cnt, bus.lock_lost_cnt};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [19:0] obs;
    e   = exp_q.pop_front();
    obs = sample();
    total++;
    assert (obs === e.exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input int cycles, input logic [19:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    exp_q.push_back(e);
    step(cycles);
    checkOutput();
  endtask

  task automatic waitState(input logic [2:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.seq_state !== target && n < budget) begin
      step(1);
      n++;
    end
    total++;
    assert (bus.seq_state === target) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, bus.seq_state, target);
    end
  endtask

  task automatic setLocks(input logic v);
    bus.plb_dcm_locked    = v;
    bus.opb_dcm_locked    = v;
    bus.ddr_fb_dcm_locked = v;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    setLocks(1'b0);
    bus.cpu_sw_rst_req = 1'b0;
    step(2);
    applyStimulus("reset", 0, mk(0, 1, 1, 1, 1, 0, 0, 0));
    rst = 1'b0;

    // Nominal start, locks arriving 10 cycles into WAIT_LOCK
    applyStimulus("t1_dcm_hold", 3, mk(0, 1, 1, 1, 1, 0, 0, 0));
    applyStimulus("t1_wait_lock", 1, mk(1, 0, 1, 1, 1, 0, 0, 0));
    step(10);
    setLocks(1'b1);
    applyStimulus("t1_sync_delay", 2, mk(1, 0, 1, 1, 1, 0, 0, 0));
    applyStimulus("t1_settle", 1, mk(2, 0, 1, 1, 1, 0, 0, 0));
    applyStimulus("t1_settle_hold", 7, mk(2, 0, 1, 1, 1, 0, 0, 0));
    applyStimulus("t1_plb_rel", 1, mk(3, 0, 0, 1, 1, 0, 0, 0));
    applyStimulus("t1_opb_hold", 3, mk(3, 0, 0, 1, 1, 0, 0, 0));
    applyStimulus("t1_opb_rel", 1, mk(3, 0, 0, 0, 1, 0, 0, 0));
    applyStimulus("t1_cpu_hold", 3, mk(3, 0, 0, 0, 1, 0, 0, 0));
    applyStimulus("t1_run", 1, mk(4, 0, 0, 0, 0, 0, 0, 0));

    // Software CPU reset with a second pulse two cycles into the stretch
    bus.cpu_sw_rst_req = 1'b1;
    applyStimulus("t5_sw_start", 1, mk(4, 0, 0, 0, 1, 0, 0, 0));
    bus.cpu_sw_rst_req = 1'b0;
    step(1);
    bus.cpu_sw_rst_req = 1'b1;
    applyStimulus("t5_second_pulse", 1, mk(4, 0, 0, 0, 1, 0, 0, 0));
    bus.cpu_sw_rst_req = 1'b0;
    applyStimulus("t5_sw_hold", 3, mk(4, 0, 0, 0, 1, 0, 0, 0));
    applyStimulus("t5_sw_end", 1, mk(4, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus("t5_no_retrigger", 4, mk(4, 0, 0, 0, 0, 0, 0, 0));

    // DDR feedback lock loss in RUN, then full re-sequence
    bus.ddr_fb_dcm_locked = 1'b0;
    applyStimulus("t4_sync_delay", 2, mk(4, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus("t4_loss", 1, mk(0, 1, 1, 1, 1, 0, 0, 1));
    bus.ddr_fb_dcm_locked = 1'b1;
    applyStimulus("t4_dcm_hold", 3, mk(0, 1, 1, 1, 1, 0, 0, 1));
    applyStimulus("t4_wait", 1, mk(1, 0, 1, 1, 1, 0, 0, 1));
    applyStimulus("t4_settle", 1, mk(2, 0, 1, 1, 1, 0, 0, 1));

    // One-cycle OPB lock glitch mid-SETTLE restarts the settle window without a retry
    step(3);
    bus.opb_dcm_locked = 1'b0;
    step(1);
    bus.opb_dcm_locked = 1'b1;
    applyStimulus("t3_still_settle", 1, mk(2, 0, 1, 1, 1, 0, 0, 1));
    applyStimulus("t3_drop", 1, mk(1, 0, 1, 1, 1, 0, 0, 1));
    applyStimulus("t3_resettle", 1, mk(2, 0, 1, 1, 1, 0, 0, 1));
    applyStimulus("t3_full_settle", 7, mk(2, 0, 1, 1, 1, 0, 0, 1));
    applyStimulus("t3_stage", 1, mk(3, 0, 0, 1, 1, 0, 0, 1));
    applyStimulus("t3_run", 8, mk(4, 0, 0, 0, 0, 0, 0, 1));

    // Locks never rise: three timed-out attempts end in FAULT
    setLocks(1'b0);
    rst = 1'b1;
    applyStimulus("t2_reset", 1, mk(0, 1, 1, 1, 1, 0, 0, 0));
    rst = 1'b0;
    applyStimulus("t2_wait1", 4, mk(1, 0, 1, 1, 1, 0, 0, 0));
    applyStimulus("t2_wait1_end", 19, mk(1, 0, 1, 1, 1, 0, 0, 0));
    applyStimulus("t2_retry1", 1, mk(0, 1, 1, 1, 1, 0, 1, 0));
    applyStimulus("t2_wait2", 4, mk(1, 0, 1, 1, 1, 0, 1, 0));
    applyStimulus("t2_retry2", 20, mk(0, 1, 1, 1, 1, 0, 2, 0));
    applyStimulus("t2_wait3_end", 23, mk(1, 0, 1, 1, 1, 0, 2, 0));
    applyStimulus("t2_fault", 1, mk(5, 1, 1, 1, 1, 1, 3, 0));
    applyStimulus("t2_fault_sticky", 10, mk(5, 1, 1, 1, 1, 1, 3, 0));

    // fpga_rst clears FAULT, and again mid-STAGE
    setLocks(1'b1);
    rst = 1'b1;
    applyStimulus("t6_clear_fault", 1, mk(0, 1, 1, 1, 1, 0, 0, 0));
    rst = 1'b0;
    waitState(3'd3, 100, "t6_reach_stage");
    applyStimulus("t6_stage", 0, mk(3, 0, 0, 1, 1, 0, 0, 0));
    rst = 1'b1;
    applyStimulus("t6_mid_reset", 1, mk(0, 1, 1, 1, 1, 0, 0, 0));
    rst = 1'b0;

    // 300 lock losses saturate the loss counter
    for (int i = 0; i < 300; i++) begin
      waitState(3'd3, 100, "t6_loop_stage");
      bus.ddr_fb_dcm_locked = 1'b0;
      waitState(3'd0, 20, "t6_loop_loss");
      bus.ddr_fb_dcm_locked = 1'b1;
      if (bad != 0) break;
    end
    applyStimulus("t6_lost_sat", 0, mk(0, 1, 1, 1, 1, 0, 0, 8'd255));
    rst = 1'b1;
    applyStimulus("t6_lost_clear", 1, mk(0, 1, 1, 1, 1, 0, 0, 0));
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
